// File: rtl/count_checker_pkg.sv
// Shared types and default parameters for the count sequence checker.
// Holds the checker FSM state encoding and the default sizing constants.
package count_checker_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      TRACK   = 2'd2
   } state_e;

   localparam int DEF_WIDTH    = 32;
   localparam int DEF_ERR_W    = 16;
   localparam int DEF_ACQ_LEN  = 2;
   localparam int DEF_MAX_MISS = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear and increment together yield 1.
// Registered output, one-cycle latency; holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc_i,
   input  logic         clr_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end
      if (inc_i && (cnt_d != '1)) begin
         cnt_d = cnt_d + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/count_checker.sv
// Checks a free-running count stream for +1 steps (or 0 after a source reset).
// All outputs registered, one-cycle latency; no backpressure, every sample is consumed.
module count_checker
   import count_checker_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int ERR_W    = DEF_ERR_W,
   parameter int ACQ_LEN  = DEF_ACQ_LEN,
   parameter int MAX_MISS = DEF_MAX_MISS
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             count_valid,
   input  logic [WIDTH-1:0] count,
   input  logic             src_rst,
   input  logic             err_clr,
   output logic             locked,
   output logic             err_pulse,
   output logic             err_sticky,
   output logic [ERR_W-1:0] err_count,
   output logic [WIDTH-1:0] expected
);

   localparam int RUN_W  = $clog2(ACQ_LEN + 1);
   localparam int MISS_W = $clog2(MAX_MISS + 1);

   state_e             state_q;
   logic [WIDTH-1:0]   expected_q;
   logic               locked_q;
   logic               err_pulse_q;
   logic               err_sticky_q;
   logic [RUN_W-1:0]   run_cnt;
   logic [MISS_W-1:0]  miss_cnt;

   logic smp;
   logic hit;
   logic acq_done;
   logic trk_err;
   logic miss_done;
   logic run_inc;
   logic run_clr;
   logic miss_inc;
   logic miss_clr;

   // A source-reset cycle is never a checkable sample.
   assign smp       = count_valid && !src_rst;
   assign hit       = (count == expected_q);
   assign acq_done  = (state_q == ACQUIRE) && smp && hit && (run_cnt == RUN_W'(ACQ_LEN - 1));
   assign trk_err   = (state_q == TRACK) && smp && !hit;
   assign miss_done = trk_err && (miss_cnt == MISS_W'(MAX_MISS - 1));

   assign run_inc  = (state_q == ACQUIRE) && smp && hit && !acq_done;
   assign run_clr  = (state_q != ACQUIRE) || (smp && !hit) || acq_done;
   assign miss_inc = trk_err && !miss_done;
   assign miss_clr = (state_q != TRACK) || (smp && hit) || miss_done;

   sat_counter #(.W(RUN_W)) u_run_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (run_inc),
      .clr_i (run_clr),
      .cnt_o (run_cnt)
   );

   sat_counter #(.W(MISS_W)) u_miss_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (miss_inc),
      .clr_i (miss_clr),
      .cnt_o (miss_cnt)
   );

   sat_counter #(.W(ERR_W)) u_err_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (trk_err),
      .clr_i (err_clr),
      .cnt_o (err_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         expected_q   <= '0;
         locked_q     <= 1'b0;
         err_pulse_q  <= 1'b0;
         err_sticky_q <= 1'b0;
      end else begin
         err_pulse_q <= trk_err;
         if (trk_err) begin
            err_sticky_q <= 1'b1;
         end else if (err_clr) begin
            err_sticky_q <= 1'b0;
         end

         if (src_rst) begin
            expected_q <= '0;
            if (state_q == IDLE) begin
               state_q <= ACQUIRE;
            end
         end else if (count_valid) begin
            // Every sample resynchronises; on a match this equals expected+1.
            expected_q <= count + WIDTH'(1);
            case (state_q)
               IDLE: begin
                  state_q <= ACQUIRE;
               end
               ACQUIRE: begin
                  if (acq_done) begin
                     state_q  <= TRACK;
                     locked_q <= 1'b1;
                  end
               end
               TRACK: begin
                  if (miss_done) begin
                     state_q  <= ACQUIRE;
                     locked_q <= 1'b0;
                  end
               end
               default: begin
                  state_q  <= IDLE;
                  locked_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign locked     = locked_q;
   assign err_pulse  = err_pulse_q;
   assign err_sticky = err_sticky_q;
   assign expected   = expected_q;

endmodule

// File: tb/tb_count_checker.sv
// Bench for count_checker: directed vector table, async-reset and idle-reset sequences,
// then random stimulus compared against a rule-level reference model.
module tb_count_checker;

   localparam int W   = 8;
   localparam int EW  = 2;
   localparam int ACQ = 2;
   localparam int MM  = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          count_valid;
   logic [W-1:0]  count;
   logic          src_rst;
   logic          err_clr;
   logic          locked;
   logic          err_pulse;
   logic          err_sticky;
   logic [EW-1:0] err_count;
   logic [W-1:0]  expected;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   count_checker #(.WIDTH(W), .ERR_W(EW), .ACQ_LEN(ACQ), .MAX_MISS(MM)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .count_valid (count_valid),
      .count       (count),
      .src_rst     (src_rst),
      .err_clr     (err_clr),
      .locked      (locked),
      .err_pulse   (err_pulse),
      .err_sticky  (err_sticky),
      .err_count   (err_count),
      .expected    (expected)
   );

   typedef struct {
      logic         v;
      logic [W-1:0] c;
      logic         s;
      logic         e;
      logic         xl;
      logic         xp;
      logic         xs;
      int           xe;
      int           xx;
   } vec_t;

   vec_t tbl[$];

   // Reference model: mode 0=idle, 1=acquiring, 2=tracking.
   int m_mode, m_exp, m_run, m_miss, m_errs;
   bit m_sticky, m_pulse;

   function automatic void add(input logic v, input int c, input logic s, input logic e,
                               input logic xl, input logic xp, input logic xs,
                               input int xe, input int xx);
      vec_t r;
      r.v = v; r.c = W'(c); r.s = s; r.e = e;
      r.xl = xl; r.xp = xp; r.xs = xs; r.xe = xe; r.xx = xx;
      tbl.push_back(r);
   endfunction

   function automatic void model_reset();
      m_mode = 0; m_exp = 0; m_run = 0; m_miss = 0; m_errs = 0;
      m_sticky = 0; m_pulse = 0;
   endfunction

   function automatic void model_step(input bit v, input int c, input bit s, input bit e);
      bit err;
      err = 0;
      if (s) begin
         m_exp = 0;
         if (m_mode == 0) begin
            m_mode = 1;
            m_run  = 0;
         end
      end else if (v) begin
         if (m_mode == 0) begin
            m_mode = 1;
            m_run  = 0;
         end else if (m_mode == 1) begin
            if (c == m_exp) begin
               m_run++;
               if (m_run >= ACQ) begin
                  m_mode = 2;
                  m_miss = 0;
               end
            end else begin
               m_run = 0;
            end
         end else begin
            if (c == m_exp) begin
               m_miss = 0;
            end else begin
               err = 1;
               m_miss++;
               if (m_miss >= MM) begin
                  m_mode = 1;
                  m_run  = 0;
                  m_miss = 0;
               end
            end
         end
         m_exp = (c + 1) % (1 << W);
      end
      m_pulse = err;
      if (err) begin
         m_sticky = 1;
         m_errs   = e ? 1 : ((m_errs + 1 > (1 << EW) - 1) ? (1 << EW) - 1 : m_errs + 1);
      end else if (e) begin
         m_sticky = 0;
         m_errs   = 0;
      end
   endfunction

   task automatic compare(input string name, input logic xl, input logic xp, input logic xs,
                          input int xe, input int xx);
      n_chk++;
      if (locked !== xl || err_pulse !== xp || err_sticky !== xs ||
          err_count !== EW'(xe) || expected !== W'(xx)) begin
         n_fail++;
         $display("FAIL %s: got locked=%0b pulse=%0b sticky=%0b errcnt=%0d expected=%0d, need locked=%0b pulse=%0b sticky=%0b errcnt=%0d expected=%0d",
                  name, locked, err_pulse, err_sticky, err_count, expected, xl, xp, xs, xe, xx);
      end
   endtask

   task automatic drive(input logic v, input int c, input logic s, input logic e);
      count_valid = v;
      count       = W'(c);
      src_rst     = s;
      err_clr     = e;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      count_valid = 0; count = '0; src_rst = 0; err_clr = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      do_reset();
      compare("reset", 0, 0, 0, 0, 0);

      // Lock on 0..3, hold with valid low, advance to 10.
      add(1, 0, 0, 0, 0, 0, 0, 0, 1);
      add(1, 1, 0, 0, 0, 0, 0, 0, 2);
      add(1, 2, 0, 0, 1, 0, 0, 0, 3);
      add(1, 3, 0, 0, 1, 0, 0, 0, 4);
      add(0, 99, 0, 0, 1, 0, 0, 0, 4);
      for (int i = 4; i < 10; i++) add(1, i, 0, 0, 1, 0, 0, 0, i + 1);
      // Single glitch.
      add(1, 10, 0, 0, 1, 0, 0, 0, 11);
      add(1, 11, 0, 0, 1, 0, 0, 0, 12);
      add(1, 20, 0, 0, 1, 1, 1, 1, 21);
      add(1, 21, 0, 0, 1, 0, 1, 1, 22);
      // Counter reset, good then bad post-reset sample.
      add(1, 7, 1, 0, 1, 0, 1, 1, 0);
      add(1, 0, 0, 0, 1, 0, 1, 1, 1);
      add(1, 1, 0, 0, 1, 0, 1, 1, 2);
      add(1, 7, 1, 0, 1, 0, 1, 1, 0);
      add(1, 5, 0, 0, 1, 1, 1, 2, 6);
      add(1, 6, 0, 0, 1, 0, 1, 2, 7);
      // Jump to 254 (error, saturates), then wrap through 0 cleanly; clear alone.
      add(1, 254, 0, 0, 1, 1, 1, 3, 255);
      add(1, 255, 0, 0, 1, 0, 1, 3, 0);
      add(1, 0, 0, 0, 1, 0, 1, 3, 1);
      add(1, 1, 0, 0, 1, 0, 1, 3, 2);
      add(0, 0, 0, 1, 1, 0, 0, 0, 2);
      // Four misses drop lock.
      add(1, 50, 0, 0, 1, 1, 1, 1, 51);
      add(1, 60, 0, 0, 1, 1, 1, 2, 61);
      add(1, 70, 0, 0, 1, 1, 1, 3, 71);
      add(1, 80, 0, 0, 0, 1, 1, 3, 81);
      // Mismatch while acquiring is silent; relock, saturate, clear with error.
      add(1, 5, 0, 0, 0, 0, 1, 3, 6);
      add(1, 6, 0, 0, 0, 0, 1, 3, 7);
      add(1, 7, 0, 0, 1, 0, 1, 3, 8);
      add(1, 90, 0, 0, 1, 1, 1, 3, 91);
      add(1, 100, 0, 1, 1, 1, 1, 1, 101);
      add(1, 101, 0, 0, 1, 0, 1, 1, 102);

      foreach (tbl[i]) begin
         drive(tbl[i].v, int'(tbl[i].c), tbl[i].s, tbl[i].e);
         compare($sformatf("vec%0d", i), tbl[i].xl, tbl[i].xp, tbl[i].xs, tbl[i].xe, tbl[i].xx);
      end

      // Async reset between edges while tracking.
      #3;
      rst_n = 1'b0;
      #1;
      compare("async_rst", 0, 0, 0, 0, 0);
      #2;
      rst_n = 1'b1;

      // Idle: valid low holds, source reset enters acquire with expected 0.
      drive(0, 0, 0, 0);   compare("idle_hold", 0, 0, 0, 0, 0);
      drive(0, 33, 1, 0);  compare("idle_srst", 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0);   compare("idle_srst_a", 0, 0, 0, 0, 1);
      drive(1, 1, 0, 0);   compare("idle_srst_b", 1, 0, 0, 0, 2);

      // Random stimulus against the model.
      do_reset();
      model_reset();
      for (int i = 0; i < 3000; i++) begin
         bit v, s, e;
         int c;
         v = ($urandom_range(0, 9) < 8);
         s = ($urandom_range(0, 19) == 0);
         e = ($urandom_range(0, 19) == 0);
         c = ($urandom_range(0, 9) < 8) ? m_exp : int'($urandom_range(0, 255));
         drive(v, c, s, e);
         model_step(v, c, s, e);
         compare($sformatf("rand%0d", i), (m_mode == 2), m_pulse, m_sticky, m_errs, m_exp);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/count_checker.md
# count_checker

Synthesizable sequence checker for the free-running `counter` block's `count` output. It samples the count stream and the counter's synchronous reset, and verifies that every accepted sample is either the previous value + 1 (modulo 2^WIDTH) or 0 following a counter reset. It reports lock status, per-error pulses and a saturating error tally. It sits beside the counter in the same clock domain, as an on-chip health monitor and as the hardware counterpart of the bench-side check.

## Interface
- WIDTH, 32, width of the monitored count.
- ERR_W, 16, width of the saturating error counter.
- ACQ_LEN, 2, consecutive correct increments required to declare lock (≥1).
- MAX_MISS, 4, consecutive mismatches in TRACK that drop lock (≥1).

Ports:
- clk, in, 1, sole clock; all state updates on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- count_valid, in, 1, `count` is a sample this cycle.
- count, in, WIDTH, monitored counter value.
- src_rst, in, 1, the monitored counter's synchronous active-high reset, as it sees it.
- err_clr, in, 1, synchronous clear of the sticky flag and the error count.
- locked, out, 1, high while in TRACK.
- err_pulse, out, 1, one-cycle pulse per detected mismatch.
- err_sticky, out, 1, set on any mismatch; held until `err_clr` or reset.
- err_count, out, ERR_W, saturating number of mismatches.
- expected, out, WIDTH, value the next valid sample must equal.

## Operation
- States: IDLE, ACQUIRE, TRACK.
- **IDLE**
  - The first valid sample without `src_rst` sets `expected = count+1` and moves to ACQUIRE.
  - No checking occurs in IDLE.
- **ACQUIRE**
  - A valid match increments the run counter. Reaching ACQ_LEN moves to TRACK.
  - A valid mismatch resets the run counter to 0 and sets `expected = count+1`.
  - No error is flagged in ACQUIRE.
- **TRACK**
  - A valid match clears the miss counter.
  - A valid mismatch does all of the following: raises `err_pulse`, sets `err_sticky`, increments `err_count` (saturating at all-ones), sets `expected = count+1` (self-resync), and increments the miss counter.
  - When the miss counter reaches MAX_MISS, go to ACQUIRE with both run and miss counters at 0.
- **Counter reset (any state)**
  - A cycle with `src_rst`=1 is never checked.
  - It forces `expected = 0` and marks the next valid sample as a post-reset sample. That sample must equal 0; it is checked under the current state's rules.
  - In IDLE, `src_rst` sets `expected = 0` and moves to ACQUIRE.
- **Arithmetic**: `expected` is computed modulo 2^WIDTH. All-ones followed by 0 is a match, not an error.
- **`count_valid` = 0**: no state change. `expected` holds.
- **Simultaneous mismatch and `err_clr`**: the error wins. Result is `err_sticky`=1 and `err_count`=1.
- **Mid-operation reset**: `rst_n` low returns to IDLE immediately. All registered state is cleared.

## Timing
- Reset values:
  - state = IDLE
  - `locked`=0, `err_pulse`=0, `err_sticky`=0, `err_count`=0, `expected`=0
- All outputs are registered.
  - A sample at edge N updates `err_pulse`, `err_sticky`, `err_count` and `expected`, visible after edge N.
  - `locked` rises after the edge that accepts the ACQ_LEN-th correct increment.
  - `locked` falls after the edge that accepts the MAX_MISS-th consecutive miss.
- `err_pulse` is high for exactly one cycle per mismatching sample. Back-to-back mismatches give back-to-back pulses.
- `src_rst` is sampled on the same edge as `count`. This matches the counter's convention: after a reset edge the count reads 0.

## Structure
- `count_checker_pkg` holds:
  - the state enum (`IDLE`, `ACQUIRE`, `TRACK`);
  - the default parameter constants.
- Sub-module `sat_counter` (parameterised width; inc, clr, and saturate at max) is used three times: for `err_count`, the acquire run counter and the miss counter.
- The remainder is one FSM plus the `expected` register.

## Test plan
1. **Reset and lock**: reset, then feed 0,1,2,3 with `count_valid`=1.
   - Required: `locked`=1 after the third sample (ACQ_LEN=2).
   - Required: no `err_pulse`; `expected`=4.
2. **Single glitch**: when locked at `expected`=10, feed 10,11,20,21.
   - Required: one `err_pulse` on the sample 20; `err_count`=1; `err_sticky`=1.
   - Required: `locked` stays 1; `expected`=22.
3. **Counter reset**: when locked, assert `src_rst` for one cycle with count=7, then feed 0,1.
   - Required: no error and `locked` holds.
   - Repeat with the post-reset sample = 5 → one `err_pulse`.
4. **Wrap**: WIDTH=8, feed 254,255,0,1.
   - Required: no error.
5. **Lock loss and saturation**: feed 4 consecutive wrong values.
   - Required: 4 pulses, then `locked`=0.
   - With ERR_W=2: `err_count` stays 3 after further errors.
   - Assert `err_clr` together with a mismatch → `err_count`=1.
6. **Async reset mid-run**: pull `rst_n` low between clock edges while in TRACK.
   - Required: all outputs are at reset values before the next edge.
